// File: rtl/ray_seq_pkg.sv
// Shared definitions for the ray column sequencer: state encoding, default
// widths and sizes, and the wall-height clamp helper.
package ray_seq_pkg;

  localparam int DIST_W   = 12;  // Q4.8 perpendicular distance
  localparam int HEIGHT_W = 9;   // wall height in pixels
  localparam int INDEX_W  = 10;  // column index
  localparam int NUM_W    = 17;  // divider numerator / quotient width

  localparam int DEF_NUM_RAYS = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_CAST  = 2'b10,
    ST_STORE = 2'b11
  } seq_state_t;

  // Limit a raw quotient to the screen height.
  function automatic logic [HEIGHT_W-1:0] clamp_height(
    input logic [NUM_W-1:0]    quot,
    input logic [HEIGHT_W-1:0] limit
  );
    return (quot > NUM_W'(limit)) ? limit : quot[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/height_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved
// in the cycle start is seen, so done pulses 17 cycles after start.
// A start while a division is running is ignored.
module height_divider
  import ray_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  num,
  input  logic [DIST_W-1:0] den,
  output logic              done,
  output logic [NUM_W-1:0]  quot
);

  logic [DIST_W-1:0] rem;
  logic [4:0]        steps_left;
  logic              load;
  logic [DIST_W-1:0] src_rem;
  logic [NUM_W-1:0]  src_quot;
  logic [DIST_W:0]   shifted;
  logic [DIST_W-1:0] next_rem;
  logic [NUM_W-1:0]  next_quot;

  assign load = start && (steps_left == '0);

  // One shift-and-subtract step, taken from fresh operands on load.
  always_comb begin
    src_rem  = load ? '0 : rem;
    src_quot = load ? num : quot;
    shifted  = {src_rem, src_quot[NUM_W-1]};
    if (shifted >= {1'b0, den}) begin
      next_rem  = DIST_W'(shifted - {1'b0, den});
      next_quot = {src_quot[NUM_W-2:0], 1'b1};
    end else begin
      next_rem  = shifted[DIST_W-1:0];
      next_quot = {src_quot[NUM_W-2:0], 1'b0};
    end
  end

  // Iteration control; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list holds only clk.
    if (reset) begin
      rem        <= '0;
      quot       <= '0;
      steps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rem        <= next_rem;
        quot       <= next_quot;
        steps_left <= 5'd16;
      end else if (steps_left != '0) begin
        rem        <= next_rem;
        quot       <= next_quot;
        steps_left <= steps_left - 5'd1;
        if (steps_left == 5'd1) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_column_sequencer.sv
// Ray-cast initiator: walks every screen column once per frame, handshakes
// each ray with the ray calculator, turns the returned distance into a
// clamped wall height and writes one column record per ray.
// Optional build macro: RAY_CASTER_TIMEOUT_EN adds a CAST watchdog that
// writes an empty column when the ray calculator never answers.
module ray_column_sequencer
  import ray_seq_pkg::*;
#(
  parameter int NUM_RAYS       = DEF_NUM_RAYS,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                ray_done,
  input  logic [DIST_W-1:0]   distance_x,
  input  logic [DIST_W-1:0]   distance_y,
  input  logic                prev_side,
  input  logic [1:0]          lighting_factor,
  input  logic [3:0]          tex_coord,
  output logic                is_new_ray,
  output logic [1:0]          fsm_state,
  output logic [INDEX_W-1:0]  ray_index,
  output logic                write_new_frame,
  output logic                col_we,
  output logic [INDEX_W-1:0]  col_addr,
  output logic [HEIGHT_W-1:0] col_height,
  output logic [1:0]          col_light,
  output logic [3:0]          col_tex,
  output logic                frame_done,
  output logic                busy,
  output logic                ray_timeout
);

  if (SETUP_CYCLES < 3 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ray_column_sequencer: SETUP_CYCLES must be >= 3, TIMEOUT_CYCLES >= 2");
  end

  localparam int                  SETUP_W    = $clog2(SETUP_CYCLES);
  localparam logic [HEIGHT_W-1:0] H_MAX      = HEIGHT_W'(SCREEN_H);
  localparam logic [NUM_W-1:0]    HEIGHT_NUM = NUM_W'(SCREEN_H << 8);
  localparam logic [INDEX_W-1:0]  LAST_RAY   = INDEX_W'(NUM_RAYS - 1);

  seq_state_t           state;
  logic [SETUP_W-1:0]   setup_cnt;
  logic [DIST_W-1:0]    dist_q;
  logic [1:0]           light_q;
  logic [3:0]           tex_q;
  logic                 zero_q;
  logic                 div_start;
  logic                 div_done;
  logic [NUM_W-1:0]     div_quot;
  logic [DIST_W-1:0]    dist_sel;
  logic                 timeout_hit;
  logic                 commit;
  logic [HEIGHT_W-1:0]  commit_height;
  logic [1:0]           commit_light;
  logic [3:0]           commit_tex;

  assign fsm_state = state;
  assign busy      = (state != ST_IDLE);
  assign dist_sel  = prev_side ? distance_y : distance_x;

  height_divider u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (HEIGHT_NUM),
    .den   (dist_q),
    .done  (div_done),
    .quot  (div_quot)
  );

`ifdef RAY_CASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] cast_cnt;

  assign timeout_hit = (state == ST_CAST) && !ray_done
                       && (cast_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in CAST; cleared everywhere else.
  always_ff @(posedge clk) begin
    if (reset || state != ST_CAST) cast_cnt <= '0;
    else                           cast_cnt <= cast_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Column record to write when a ray finishes (or times out).
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is built.
    commit        = ((state == ST_STORE) && (zero_q || div_done)) || timeout_hit;
    commit_height = zero_q ? H_MAX : clamp_height(div_quot, H_MAX);
    commit_light  = light_q;
    commit_tex    = tex_q;
    if (timeout_hit) begin
      commit_height = '0;
      commit_light  = '0;
      commit_tex    = '0;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      setup_cnt       <= '0;
      ray_index       <= '0;
      write_new_frame <= 1'b0;
      is_new_ray      <= 1'b0;
      col_we          <= 1'b0;
      col_addr        <= '0;
      col_height      <= '0;
      col_light       <= '0;
      col_tex         <= '0;
      frame_done      <= 1'b0;
      ray_timeout     <= 1'b0;
      dist_q          <= '0;
      light_q         <= '0;
      tex_q           <= '0;
      zero_q          <= 1'b0;
      div_start       <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values; pulses default low and are raised below.
      is_new_ray  <= 1'b0;
      col_we      <= 1'b0;
      frame_done  <= 1'b0;
      div_start   <= 1'b0;
      ray_timeout <= timeout_hit;

      unique case (state)
        ST_IDLE: begin
          // A request colliding with the end-of-frame pulse is dropped.
          if (frame_start && !frame_done) begin
            write_new_frame <= 1'b1;
            ray_index       <= '0;
            setup_cnt       <= '0;
            is_new_ray      <= 1'b1;
            state           <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // ray_done is stale here and deliberately not looked at.
          if (setup_cnt == SETUP_W'(SETUP_CYCLES - 1)) state <= ST_CAST;
          else setup_cnt <= setup_cnt + 1'b1;
        end
        ST_CAST: begin
          if (ray_done) begin
            dist_q    <= dist_sel;
            light_q   <= lighting_factor;
            tex_q     <= tex_coord;
            zero_q    <= (dist_sel == '0);
            div_start <= (dist_sel != '0);
            state     <= ST_STORE;
          end
        end
        ST_STORE: ;
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        col_we     <= 1'b1;
        col_addr   <= ray_index;
        col_height <= commit_height;
        col_light  <= commit_light;
        col_tex    <= commit_tex;
        if (ray_index == LAST_RAY) begin
          frame_done      <= 1'b1;
          write_new_frame <= 1'b0;
          state           <= ST_IDLE;
        end else begin
          ray_index  <= ray_index + 1'b1;
          setup_cnt  <= '0;
          is_new_ray <= 1'b1;
          state      <= ST_SETUP;
        end
      end
    end
  end

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Directed bench for ray_column_sequencer: single-ray height vectors, a full
// 640-column frame, stale ray_done, ignored frame_start, mid-frame reset and,
// when RAY_CASTER_TIMEOUT_EN is defined, the CAST watchdog.
module tb_ray_column_sequencer;
  import ray_seq_pkg::*;

  localparam int NUM_RAYS     = 640;
  localparam int SETUP_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        ray_done = 1'b0;
  logic [11:0] distance_x = '0;
  logic [11:0] distance_y = '0;
  logic        prev_side = 1'b0;
  logic [1:0]  lighting_factor = '0;
  logic [3:0]  tex_coord = '0;
  logic        is_new_ray, write_new_frame, col_we, frame_done, busy, ray_timeout;
  logic [1:0]  fsm_state, col_light;
  logic [9:0]  ray_index, col_addr;
  logic [8:0]  col_height;
  logic [3:0]  col_tex;

  ray_column_sequencer #(
    .NUM_RAYS(NUM_RAYS), .SCREEN_H(480), .SETUP_CYCLES(SETUP_CYCLES), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ray_done(ray_done),
    .distance_x(distance_x), .distance_y(distance_y), .prev_side(prev_side),
    .lighting_factor(lighting_factor), .tex_coord(tex_coord),
    .is_new_ray(is_new_ray), .fsm_state(fsm_state), .ray_index(ray_index),
    .write_new_frame(write_new_frame), .col_we(col_we), .col_addr(col_addr),
    .col_height(col_height), .col_light(col_light), .col_tex(col_tex),
    .frame_done(frame_done), .busy(busy), .ray_timeout(ray_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {int addr; int height; int light; int tex; int lat;} col_rec_t;
  col_rec_t cols[$];
  int fd_count = 0;
  int nr_count = 0;
  int t_new = 0;
  bit prev_wnf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (fsm_state !== s && n < 100) begin tick(); n++; end
    if (fsm_state !== s) check(tag, fsm_state, s);
  endtask

  task automatic wait_new_ray(input string tag);
    int n = 0;
    while (is_new_ray !== 1'b1 && n < 100) begin tick(); n++; end
    if (is_new_ray !== 1'b1) check(tag, is_new_ray, 1);
  endtask

  // Present one ray's results, raising ray_done dly cycles into CAST.
  task automatic serve(input int dly, input logic side, input logic [11:0] dx,
                       input logic [11:0] dy, input logic [1:0] lt,
                       input logic [3:0] tx, input bit keep);
    prev_side = side; distance_x = dx; distance_y = dy;
    lighting_factor = lt; tex_coord = tx;
    wait_state(ST_CAST, "wait_cast");
    repeat (dly) tick();
    ray_done = 1'b1;
    tick();
    if (!keep) ray_done = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Record column writes with their latency from the ray's is_new_ray.
  always @(negedge clk) begin
    if (!reset) begin
      if (col_we) cols.push_back('{int'(col_addr), int'(col_height), int'(col_light),
                                   int'(col_tex), cyc - t_new});
      if (is_new_ray) begin nr_count++; t_new = cyc; end
      if (frame_done) begin
        fd_count++;
        check("fd_wnf_low", write_new_frame, 0);
        check("fd_wnf_was_high", prev_wnf, 1);
        check("fd_with_last_write", {col_we, col_addr}, {1'b1, 10'(NUM_RAYS - 1)});
      end
      prev_wnf = write_new_frame;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  int exp_h[6]   = '{480, 240, 30, 480, 480, 320};
  int exp_l[6]   = '{2, 1, 3, 0, 2, 1};
  int exp_t[6]   = '{10, 3, 15, 5, 7, 9};
  int exp_lat[6] = '{23, 25, 23, 23, 6, 23};

  initial begin
    int n;
    int bad;

    // Reset state
    repeat (3) tick();
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_flags", {busy, write_new_frame, col_we, is_new_ray, frame_done, ray_timeout}, 0);
    check("rst_index", ray_index, 0);
    check("rst_col", {col_addr, col_height, col_light, col_tex}, 0);
    reset = 1'b0;
    tick();

    // Frame accept
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("start_state", fsm_state, ST_SETUP);
    check("start_flags", {is_new_ray, write_new_frame, busy}, 3'b111);
    check("start_index", ray_index, 0);
    tick();
    check("new_ray_one_cycle", is_new_ray, 0);

    // Directed height vectors on rays 0..4
    serve(0, 1'b0, 12'h100, 12'h7FF, 2'd2, 4'hA, 1'b0);
    serve(2, 1'b1, 12'h050, 12'h200, 2'd1, 4'h3, 1'b0);
    serve(0, 1'b0, 12'hFFF, 12'h010, 2'd3, 4'hF, 1'b0);
    serve(0, 1'b1, 12'hFFF, 12'h0F0, 2'd0, 4'h5, 1'b0);
    serve(0, 1'b0, 12'h000, 12'h100, 2'd2, 4'h7, 1'b1);

    // Ray 5: ray_done still high from ray 4 must not cut SETUP short
    wait_new_ray("held_new_ray");
    prev_side = 1'b0; distance_x = 12'h180; lighting_factor = 2'd1; tex_coord = 4'h9;
    n = 0;
    while (fsm_state == ST_SETUP && n < 10) begin n++; tick(); end
    check("held_setup_len", n, SETUP_CYCLES);
    check("held_cast", fsm_state, ST_CAST);
    tick();
    check("held_store", fsm_state, ST_STORE);
    ray_done = 1'b0;

    // Remaining rays; a frame_start at ray 100 must be ignored
    for (int i = 6; i < NUM_RAYS; i++) begin
      if (i == 100) begin
        wait_new_ray("wait_ray_100");
        check("index_100", ray_index, 100);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("start_ignored", {fsm_state, write_new_frame, ray_index}, {2'b01, 1'b1, 10'd100});
      end
      serve(5, 1'b0, 12'h400, 12'h001, 2'd1, 4'h4, 1'b0);
    end

    // frame_start during the frame_done cycle is dropped
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin tick(); n++; end
    check("frame_done_seen", frame_done, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("end_idle", {fsm_state, busy, write_new_frame}, 0);
    check("frame_done_one_cycle", frame_done, 0);
    repeat (3) tick();

    check("write_count", cols.size(), NUM_RAYS);
    check("frame_done_count", fd_count, 1);
    check("new_ray_count", nr_count, NUM_RAYS);
    if (cols.size() == NUM_RAYS) begin
      bad = 0;
      foreach (cols[k]) if (cols[k].addr != k) bad++;
      check("addr_order_bad", bad, 0);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("r%0d_height", k), cols[k].height, exp_h[k]);
        check($sformatf("r%0d_light", k), cols[k].light, exp_l[k]);
        check($sformatf("r%0d_tex", k), cols[k].tex, exp_t[k]);
        check($sformatf("r%0d_latency", k), cols[k].lat, exp_lat[k]);
      end
      bad = 0;
      for (int k = 6; k < NUM_RAYS; k++)
        if (cols[k].height != 120 || cols[k].light != 1 || cols[k].tex != 4 || cols[k].lat != 28)
          bad++;
      check("bulk_rays_bad", bad, 0);
    end

    // Mid-frame reset at ray 300 abandons the frame
    cols.delete(); fd_count = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 300; i++) serve(5, 1'b1, 12'h001, 12'h200, 2'd3, 4'hC, 1'b0);
    wait_new_ray("wait_ray_300");
    check("index_300", ray_index, 300);
    check("pre_reset_col", {col_we, col_addr, col_height}, {1'b1, 10'd299, 9'd240});
    reset = 1'b1; tick();
    check("mid_rst_state", fsm_state, ST_IDLE);
    check("mid_rst_flags", {busy, write_new_frame, col_we, is_new_ray, frame_done, ray_timeout}, 0);
    check("mid_rst_index", ray_index, 0);
    check("mid_rst_col", {col_addr, col_height, col_light, col_tex}, 0);
    reset = 1'b0;
    repeat (30) tick();
    check("mid_rst_no_frame_done", fd_count, 0);
    check("mid_rst_stays_idle", fsm_state, ST_IDLE);

`ifdef RAY_CASTER_TIMEOUT_EN
    // Watchdog: ray 1 never answers
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    serve(0, 1'b0, 12'h100, 12'h000, 2'd3, 4'hF, 1'b0);
    wait_state(ST_CAST, "to_wait_cast");
    n = 0;
    while (fsm_state == ST_CAST && n < 1200) begin n++; tick(); end
    check("to_cast_cycles", n, 1024);
    check("to_pulse", ray_timeout, 1);
    check("to_write", {col_we, col_addr}, {1'b1, 10'd1});
    check("to_col", {col_height, col_light, col_tex}, 0);
    check("to_advance", {fsm_state, ray_index}, {2'b01, 10'd2});
    tick();
    check("to_pulse_end", ray_timeout, 0);
    reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ray_column_sequencer.md
Name: ray_column_sequencer

Overview:
Initiator side of the ray-cast interface. Walks ray_index across all screen columns once per frame and drives the per-ray setup handshake into the ray calculator. Waits for each ray's completion and converts the returned perpendicular distance into a clamped wall height with a sequential divider. Writes one column record (height, lighting, texture column) per ray into the column buffer that the pixel/VGA side reads.

Parameters:
NUM_RAYS, 640, columns per frame; ray_index runs 0..NUM_RAYS-1.
SCREEN_H, 480, screen height in pixels; the maximum wall height.
SETUP_CYCLES, 4, cycles fsm_state is held at SETUP per ray; minimum 3.
TIMEOUT_CYCLES, 1024, CAST watchdog limit; used only with RAY_CASTER_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle request to render a frame
ray_done  in  1  ray calculator finished current ray
distance_x  in  12  Q4.8 distance, valid when prev_side=0
distance_y  in  12  Q4.8 distance, valid when prev_side=1
prev_side  in  1  0 = vertical wall hit, 1 = horizontal wall hit
lighting_factor  in  2  shade code from ray calculator
tex_coord  in  4  texture column from ray calculator
is_new_ray  out  1  one-cycle pulse at the start of each ray
fsm_state  out  2  00 IDLE, 01 SETUP, 10 CAST, 11 STORE
ray_index  out  10  current column
write_new_frame  out  1  high from frame accept until frame_done
col_we  out  1  column buffer write strobe
col_addr  out  10  column buffer address (equals ray_index)
col_height  out  9  wall height in pixels, 0..SCREEN_H
col_light  out  2  latched lighting_factor
col_tex  out  4  latched tex_coord
frame_done  out  1  one-cycle pulse after the last column is written
busy  out  1  high whenever the FSM is not in IDLE
ray_timeout  out  1  one-cycle pulse when the watchdog fires (feature only)

Behaviour:
- Reset: the FSM goes to IDLE and every output is 0, including ray_index and col_* registers. The divider aborts. A reset applied mid-frame abandons the frame with no frame_done.
- IDLE, frame_start=1: set write_new_frame=1, ray_index=0, go to SETUP. frame_start is ignored in every other state; no queuing.
- SETUP: is_new_ray=1 on the entry cycle only. Hold fsm_state=01 for exactly SETUP_CYCLES cycles, then go to CAST. ray_done is ignored in SETUP because it is stale from the previous ray.
- CAST: on ray_done=1, latch dist = prev_side ? distance_y : distance_x, and latch lighting_factor, tex_coord and prev_side. Start the divider and go to STORE. ray_done must be seen high in CAST; level is sufficient.
- STORE: wait for div_done. Next cycle: col_we=1 for one cycle with col_addr=ray_index and col_height = min(quotient, SCREEN_H).
  - If ray_index=NUM_RAYS-1: pulse frame_done, clear write_new_frame, go to IDLE.
  - Otherwise: increment ray_index and go to SETUP. No wrap beyond NUM_RAYS-1.
- Height arithmetic: quotient = (SCREEN_H<<8) / dist, unsigned, 17-bit numerator, 12-bit divisor.
  - dist=0 bypasses the divider and gives height=SCREEN_H one cycle later.
  - Results above SCREEN_H clamp to SCREEN_H.
- Divider: restoring, one quotient bit per cycle. Latency is 17 cycles from start to div_done. Never restarted while running.
- Per-ray latency, excluding CAST wait: 1 + SETUP_CYCLES + 17 + 1 cycles.
- Simultaneous events: reset wins over everything. frame_start arriving in the same cycle as frame_done is ignored.

Optional Feature:
RAY_CASTER_TIMEOUT_EN.
- Defined: a counter runs in CAST. When it reaches TIMEOUT_CYCLES without ray_done, pulse ray_timeout, write the column with col_height=0, col_light=0 and col_tex=0, then continue with the normal index advance.
- Undefined: CAST waits indefinitely, the counter is absent and ray_timeout is tied to 0.

Decomposition:
Package ray_seq_pkg holds:
- the fsm_state encoding constants (IDLE/SETUP/CAST/STORE);
- the default widths: DIST_W=12, HEIGHT_W=9, INDEX_W=10;
- the default NUM_RAYS and SCREEN_H.
One sub-module: height_divider, a restoring divider with start, num[16:0], den[11:0], done and quot[16:0].

Test Plan:
- Single ray, prev_side=0, distance_x=0x100 (1.0): col_height=480, col_addr=0, col_light and col_tex equal the inputs.
- distance_y=0x200, prev_side=1: col_height=240. distance_x=0xFFF: col_height=30. distance=0x0F0: quotient 512 clamps to 480. distance=0: col_height=480.
- Full frame with a responder model asserting ray_done 5 cycles into CAST:
  - 640 col_we pulses at addresses 0..639 in order;
  - exactly one frame_done pulse;
  - write_new_frame drops with frame_done;
  - one is_new_ray per ray.
- ray_done held high from the previous ray during SETUP: no premature STORE; the ray is accepted only after CAST is entered.
- frame_start pulsed at ray_index=100: ignored, frame completes normally. Reset asserted at ray_index=300: next cycle all outputs 0 and fsm_state=00, with no frame_done.
- With RAY_CASTER_TIMEOUT_EN and TIMEOUT_CYCLES=1024, ray_done never asserted: ray_timeout pulses after 1024 CAST cycles, col_height=0 is written and ray_index advances.
